// File: rtl/sdram_arbiter_if.sv
// Bundle of client A, client B and SDRAM controller signals seen by the arbiter.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    logic              i_A_Request;
    logic [1:0]        i_A_Command;
    logic [ADDR_W-1:0] i_A_Address;
    logic [DATA_W-1:0] i_A_Data_Write;
    logic              o_A_Grant;
    logic              o_A_Data_Read_Valid;
    logic              o_A_Data_Write_Done;

    logic [1:0]        i_B_Command;
    logic [ADDR_W-1:0] i_B_Address;
    logic [DATA_W-1:0] i_B_Data_Write;
    logic              i_B_Yield;
    logic              o_B_Requested;
    logic              o_B_Data_Read_Valid;
    logic              o_B_Data_Write_Done;

    logic [1:0]        o_Command;
    logic [ADDR_W-1:0] o_Data_Address;
    logic [DATA_W-1:0] o_Data_Write;
    logic              i_Data_Read_Valid;
    logic              i_Data_Write_Done;
    logic              i_Ctrl_Busy;

    modport slave (
        input  i_A_Request, i_A_Command, i_A_Address, i_A_Data_Write,
        output o_A_Grant, o_A_Data_Read_Valid, o_A_Data_Write_Done,
        input  i_B_Command, i_B_Address, i_B_Data_Write, i_B_Yield,
        output o_B_Requested, o_B_Data_Read_Valid, o_B_Data_Write_Done,
        output o_Command, o_Data_Address, o_Data_Write,
        input  i_Data_Read_Valid, i_Data_Write_Done, i_Ctrl_Busy
    );

    modport master (
        output i_A_Request, i_A_Command, i_A_Address, i_A_Data_Write,
        input  o_A_Grant, o_A_Data_Read_Valid, o_A_Data_Write_Done,
        output i_B_Command, i_B_Address, i_B_Data_Write, i_B_Yield,
        input  o_B_Requested, o_B_Data_Read_Valid, o_B_Data_Write_Done,
        input  o_Command, o_Data_Address, o_Data_Write,
        output i_Data_Read_Valid, i_Data_Write_Done, i_Ctrl_Busy
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-client SDRAM port arbiter: LCD reader (A, priority) preempts the
// fractal engine (B, default owner) via a request/yield handshake.
module sdram_arbiter #(
    parameter int ADDR_W       = 22,
    parameter int DATA_W       = 32,
    parameter int B_MIN_CYCLES = 16
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    sdram_arbiter_if.slave  bus
);
    localparam logic [1:0] CMD_IDLE = 2'd0;

    localparam logic [1:0] OWN_B   = 2'd0;
    localparam logic [1:0] DRAIN_B = 2'd1;
    localparam logic [1:0] OWN_A   = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam int GW = (B_MIN_CYCLES > 0) ? $clog2(B_MIN_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GUARD_INIT = GW'(B_MIN_CYCLES);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          grant_q, grant_d;
    logic          req_q, req_d;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        guard_d = guard_q;
        grant_d = grant_q;
        req_d   = req_q;
        unique case (state_q)
            OWN_B: begin
                if (guard_q != '0) guard_d = guard_q - GW'(1);
                if (bus.i_A_Request && guard_q == '0) begin
                    state_d = DRAIN_B;
                    req_d   = 1'b1;
                end
            end
            DRAIN_B: begin
                // A withdrawing takes precedence over a simultaneous yield
                if (!bus.i_A_Request) begin
                    state_d = OWN_B;
                    req_d   = 1'b0;
                end else if (bus.i_B_Yield && !bus.i_Ctrl_Busy) begin
                    state_d = OWN_A;
                    grant_d = 1'b1;
                    owner_d = 1'b1;
                end
            end
            OWN_A: begin
                if (!bus.i_A_Request && !bus.i_Ctrl_Busy) begin
                    state_d = RELEASE;
                    grant_d = 1'b0;
                end
            end
            RELEASE: begin
                state_d = OWN_B;
                guard_d = GUARD_INIT;
                req_d   = 1'b0;
                owner_d = 1'b0;
            end
            default: state_d = OWN_B;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= OWN_B;
            owner_q <= 1'b0;
            guard_q <= '0;
            grant_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            guard_q <= guard_d;
            grant_q <= grant_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        bus.o_Command      = bus.i_B_Command;
        bus.o_Data_Address = bus.i_B_Address;
        bus.o_Data_Write   = bus.i_B_Data_Write;
        if (owner_q) begin
            bus.o_Command      = bus.i_A_Command;
            bus.o_Data_Address = bus.i_A_Address;
            bus.o_Data_Write   = bus.i_A_Data_Write;
        end
        // One dead cycle on hand-back so A's last command never leaks into B's slot
        if (i_Reset || state_q == RELEASE) bus.o_Command = CMD_IDLE;
    end

    assign bus.o_A_Grant           = grant_q;
    assign bus.o_B_Requested       = req_q;
    assign bus.o_A_Data_Read_Valid = owner_q & bus.i_Data_Read_Valid;
    assign bus.o_A_Data_Write_Done = owner_q & bus.i_Data_Write_Done;
    assign bus.o_B_Data_Read_Valid = ~owner_q & bus.i_Data_Read_Valid;
    assign bus.o_B_Data_Write_Done = ~owner_q & bus.i_Data_Write_Done;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; strobe routing checked through a scoreboard.
module tb_sdram_arbiter;
    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_READ  = 2'd1;
    localparam logic [1:0] C_WRITE = 2'd2;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    // {a_rv, a_wd, b_rv, b_wd}
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(22), .DATA_W(32)) bus ();

    sdram_arbiter #(
        .ADDR_W(22), .DATA_W(32), .B_MIN_CYCLES(16)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst),
        .bus(bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] got;
        logic [3:0] e;
        got = {bus.o_A_Data_Read_Valid, bus.o_A_Data_Write_Done,
               bus.o_B_Data_Read_Valid, bus.o_B_Data_Write_Done};
        if (got != 4'b0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got %b expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL strobe_route: got %b expected %b", got, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.i_A_Request       = 1'b0;
        bus.i_A_Command       = C_WRITE;
        bus.i_A_Address       = 22'h1000;
        bus.i_A_Data_Write    = 32'hA0A0_0002;
        bus.i_B_Command       = C_READ;
        bus.i_B_Address       = 22'h20000;
        bus.i_B_Data_Write    = 32'hB0B0_0001;
        bus.i_B_Yield         = 1'b0;
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Data_Write_Done = 1'b0;
        bus.i_Ctrl_Busy       = 1'b0;

        // reset
        step();
        #1;
        chk("rst_cmd_idle", 32'(bus.o_Command), 32'(C_IDLE));
        chk("rst_grant", 32'(bus.o_A_Grant), 0);
        chk("rst_req", 32'(bus.o_B_Requested), 0);
        step();
        rst = 1'b0;
        #1;
        chk("b_cmd", 32'(bus.o_Command), 32'(C_READ));
        chk("b_addr", 32'(bus.o_Data_Address), 32'h20000);
        chk("b_wdata", bus.o_Data_Write, 32'hB0B0_0001);
        chk("b_grant0", 32'(bus.o_A_Grant), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.i_Data_Read_Valid = 1'b1;
            exp_q.push_back(4'b0010);
        end
        step();
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Data_Write_Done = 1'b1;
        exp_q.push_back(4'b0001);
        step();
        bus.i_Data_Write_Done = 1'b0;

        // A requests while B is mid-burst
        step();
        bus.i_A_Request = 1'b1;
        bus.i_A_Command = C_READ;
        bus.i_Ctrl_Busy = 1'b1;
        bus.i_B_Command = C_WRITE;
        bus.i_B_Address = 22'h20004;
        #1;
        chk("req_not_yet", 32'(bus.o_B_Requested), 0);
        chk("a_cmd_ignored", 32'(bus.o_Command), 32'(C_WRITE));
        for (int i = 0; i < 5; i++) begin
            step();
            bus.i_Data_Write_Done = (i == 2);
            if (i == 2) exp_q.push_back(4'b0001);
            #1;
            chk("drain_req", 32'(bus.o_B_Requested), 1);
            chk("drain_grant", 32'(bus.o_A_Grant), 0);
            chk("drain_b_addr", 32'(bus.o_Data_Address), 32'h20004);
        end
        step();
        bus.i_Data_Write_Done = 1'b0;
        bus.i_Ctrl_Busy = 1'b0;
        bus.i_B_Yield = 1'b1;
        #1;
        chk("grant_before_yield", 32'(bus.o_A_Grant), 0);
        step();
        bus.i_B_Yield = 1'b0;
        #1;
        chk("grant_after_yield", 32'(bus.o_A_Grant), 1);
        chk("a_cmd", 32'(bus.o_Command), 32'(C_READ));
        chk("a_addr", 32'(bus.o_Data_Address), 32'h1000);
        chk("a_wdata", bus.o_Data_Write, 32'hA0A0_0002);
        chk("own_a_req", 32'(bus.o_B_Requested), 1);

        // A reads 8 words then releases
        for (int i = 0; i < 8; i++) begin
            step();
            bus.i_Ctrl_Busy = 1'b1;
            bus.i_Data_Read_Valid = 1'b1;
            exp_q.push_back(4'b1000);
        end
        step();
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Ctrl_Busy = 1'b0;
        bus.i_A_Request = 1'b0;
        bus.i_B_Command = C_READ;
        bus.i_B_Address = 22'h20000;
        #1;
        chk("grant_hold", 32'(bus.o_A_Grant), 1);
        step();
        bus.i_Data_Write_Done = 1'b1;
        exp_q.push_back(4'b0100);
        #1;
        chk("release_idle", 32'(bus.o_Command), 32'(C_IDLE));
        chk("release_grant", 32'(bus.o_A_Grant), 0);
        chk("release_req", 32'(bus.o_B_Requested), 1);
        step();
        bus.i_Data_Write_Done = 1'b0;
        bus.i_A_Request = 1'b1;
        #1;
        chk("back_b_cmd", 32'(bus.o_Command), 32'(C_READ));
        chk("back_b_addr", 32'(bus.o_Data_Address), 32'h20000);
        chk("back_req", 32'(bus.o_B_Requested), 0);

        // guard window holds off the re-request
        for (int k = 1; k <= 16; k++) begin
            step();
            #1;
            chk("guard_req_low", 32'(bus.o_B_Requested), 0);
        end
        step();
        #1;
        chk("guard_req_high", 32'(bus.o_B_Requested), 1);

        // request drop and yield in the same cycle
        bus.i_A_Request = 1'b0;
        bus.i_B_Yield = 1'b1;
        step();
        #1;
        chk("drop_req", 32'(bus.o_B_Requested), 0);
        chk("drop_grant", 32'(bus.o_A_Grant), 0);
        chk("drop_b_cmd", 32'(bus.o_Command), 32'(C_READ));
        bus.i_A_Request = 1'b1;
        bus.i_B_Yield = 1'b0;
        step();
        #1;
        chk("guard_kept_zero", 32'(bus.o_B_Requested), 1);
        chk("no_grant_yet", 32'(bus.o_A_Grant), 0);
        bus.i_B_Yield = 1'b1;
        step();
        bus.i_B_Yield = 1'b0;
        #1;
        chk("regrant", 32'(bus.o_A_Grant), 1);

        // reset during an A burst
        bus.i_Ctrl_Busy = 1'b1;
        bus.i_Data_Read_Valid = 1'b1;
        exp_q.push_back(4'b1000);
        step();
        bus.i_Data_Read_Valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid_idle", 32'(bus.o_Command), 32'(C_IDLE));
        step();
        #1;
        chk("rst_mid_grant", 32'(bus.o_A_Grant), 0);
        chk("rst_mid_req", 32'(bus.o_B_Requested), 0);
        chk("rst_mid_idle2", 32'(bus.o_Command), 32'(C_IDLE));
        rst = 1'b0;
        bus.i_Ctrl_Busy = 1'b0;
        bus.i_A_Request = 1'b0;
        bus.i_Data_Read_Valid = 1'b1;
        exp_q.push_back(4'b0010);
        #1;
        chk("rst_owner_b_cmd", 32'(bus.o_Command), 32'(C_READ));
        step();
        bus.i_Data_Read_Valid = 1'b0;
        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between two clients.
- Client A is the LCD scanout reader: high priority, explicit request/grant.
- Client B is the fractal compute engine: default owner, released through its requested/yield handshake.
- Sits between both clients and the SDRAM controller; muxes command, address and write data, and routes the read-valid and write-done strobes back to the current owner.

Parameters:
- ADDR_W, 22, SDRAM word address width.
- DATA_W, 32, SDRAM data width.
- B_MIN_CYCLES, 16, cycles B is guaranteed to own the bus after each return before A can preempt again (0 = no guard).

Ports:
- i_Clk  in  1  system/SDRAM clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_A_Request  in  1  A wants the bus (level); held until A's last burst completes.
- i_A_Command  in  2  A command (CMD_IDLE/CMD_READ/CMD_WRITE from the shared SDRAM encoding).
- i_A_Address  in  ADDR_W  A address.
- i_A_Data_Write  in  DATA_W  A write data.
- o_A_Grant  out  1  A owns the bus.
- o_A_Data_Read_Valid  out  1  read strobe routed to A.
- o_A_Data_Write_Done  out  1  write strobe routed to A.
- i_B_Command  in  2  B command.
- i_B_Address  in  ADDR_W  B address.
- i_B_Data_Write  in  DATA_W  B write data.
- i_B_Yield  in  1  B is idle and releases the bus.
- o_B_Requested  out  1  asks B to yield.
- o_B_Data_Read_Valid  out  1  read strobe routed to B.
- o_B_Data_Write_Done  out  1  write strobe routed to B.
- o_Command  out  2  command to the controller.
- o_Data_Address  out  ADDR_W  address to the controller.
- o_Data_Write  out  DATA_W  write data to the controller.
- i_Data_Read_Valid  in  1  controller read strobe.
- i_Data_Write_Done  in  1  controller write strobe.
- i_Ctrl_Busy  in  1  controller has a burst in flight.

Behaviour:
- States: OWN_B, DRAIN_B, OWN_A, RELEASE. Registered owner bit: 0 = B, 1 = A.
- Reset:
  - state = OWN_B, owner = B, guard = 0.
  - o_A_Grant = 0, o_B_Requested = 0.
  - o_Command = CMD_IDLE on every cycle that reset is asserted.
  - Reset mid-burst abandons the burst with no drain.
- OWN_B:
  - o_Command/address/write data = B inputs, combinational.
  - guard decrements to 0 and saturates there.
  - If i_A_Request && guard == 0, go to DRAIN_B. o_B_Requested rises the following cycle (registered).
- DRAIN_B:
  - o_B_Requested = 1; B inputs are still passed through so B can finish its burst.
  - If i_B_Yield && !i_Ctrl_Busy, go to OWN_A.
  - If i_A_Request drops first, go to OWN_B with guard unchanged.
  - If yield and request-drop happen in the same cycle, request-drop wins.
- OWN_A:
  - o_A_Grant = 1 (registered; rises 1 cycle after the yield is sampled).
  - Mux selects A inputs; o_B_Requested stays 1.
  - If !i_A_Request && !i_Ctrl_Busy, go to RELEASE.
- RELEASE:
  - Exactly 1 cycle; o_Command forced to CMD_IDLE; o_A_Grant = 0.
  - Next state OWN_B; guard loaded with B_MIN_CYCLES; o_B_Requested drops on entry to OWN_B.
- Strobe routing:
  - i_Data_Read_Valid and i_Data_Write_Done go only to the owner's outputs, combinational, zero latency.
  - Owner flips to A on entry to OWN_A and back to B on entry to OWN_B.
  - Strobes arriving in RELEASE go to A.
  - The non-owner's strobe outputs are always 0.
- Latency from A request to A's first command: 2 cycles minimum when B yields immediately (1 cycle for request-to-DRAIN_B, 1 cycle for yield-to-OWN_A).
- Guard counter width: clog2(B_MIN_CYCLES+1); with B_MIN_CYCLES = 0 the guard is always 0.
- i_A_Command is ignored when A does not own the bus. A issuing a command without grant is legal and has no effect.

Test Plan:
- Reset, then B issues CMD_READ at 0x20000 -> o_Command = READ, o_Data_Address = 0x20000, B's read strobes route to B, o_A_Grant = 0.
- A raises request while B is mid-burst (i_Ctrl_Busy = 1, yield = 0 for 5 cycles) -> o_B_Requested = 1; o_A_Grant stays 0 until busy drops and yield = 1, then rises 1 cycle later.
- A owns the bus and reads 8 words at 0x1000 -> exactly 8 o_A_Data_Read_Valid pulses, 0 on B. A drops request -> 1 CMD_IDLE cycle, then B is muxed back.
- B_MIN_CYCLES = 16: A re-requests right after release -> o_B_Requested stays 0 for 16 cycles, then asserts.
- A drops request during DRAIN_B in the same cycle B yields -> return to OWN_B, o_A_Grant never asserts, guard unchanged.
- Reset asserted during OWN_A burst -> next cycle o_Command = CMD_IDLE, o_A_Grant = 0, owner = B.
